timer_8bit: RTL and testbench

- 8-bit programmable up/down timer with an APB slave register interface.
- Sits behind the AHB-to-APB bridge on one peripheral select; CPU software programs it through AHB writes to bridge slot 1 (base 0xC010).
- Counts on a prescaled PCLK tick, supports loading from a data register, and latches overflow/underflow flags in a status register.

---
 rtl/timer_8bit.sv | 160 ++++++++++++++++
 tb/tb_timer_8bit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/timer_8bit.sv
// 8-bit programmable up/down timer behind an APB slave interface.
// The timer counts on a prescaled pclk tick, can be reloaded from TDR, and
// latches sticky overflow and underflow flags in TSR.
`timescale 1ns/1ps

module timer_8bit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam logic [1:0] AddrTdr  = 2'd0;
  localparam logic [1:0] AddrTcr  = 2'd1;
  localparam logic [1:0] AddrTsr  = 2'd2;
  localparam logic [1:0] AddrTcnt = 2'd3;

  // Programmer-visible state
  logic [7:0]        r_tdr;
  logic [7:0]        r_tcnt;
  logic              r_load;
  logic              r_down;
  logic              r_en;
  logic [1:0]        r_cks;
  logic              r_ovf;
  logic              r_udf;
  logic [3:0]        r_psc;
  logic [DATA_W-1:0] r_prdata;

  logic              w_access;
  logic              w_addr_ok;
  logic              w_wr;
  logic              w_setup_rd;
  logic              w_tdr_wr;
  logic              w_tcr_wr;
  logic              w_tsr_wr;
  logic              w_run;
  logic [3:0]        w_psc_last;
  logic              w_tick;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic [DATA_W-1:0] w_rdata;

  // APB decode; anything above TCNT is an error and must have no side effect
  assign w_access   = psel & penable;
  assign w_addr_ok  = (paddr <= ADDR_W'(3));
  assign w_wr       = w_access & pwrite & w_addr_ok;
  assign w_setup_rd = psel & ~penable & ~pwrite;
  assign w_tdr_wr   = w_wr & (paddr[1:0] == AddrTdr);
  assign w_tcr_wr   = w_wr & (paddr[1:0] == AddrTcr);
  assign w_tsr_wr   = w_wr & (paddr[1:0] == AddrTsr);

  assign pready  = w_access;
  assign pslverr = w_access & ~w_addr_ok;
  assign prdata  = r_prdata;

  // Prescaler terminal count N-1 where N = 2^(CKS+1)
  always_comb begin
    w_psc_last = 4'd1;
    case (r_cks)
      2'd0:    w_psc_last = 4'd1;
      2'd1:    w_psc_last = 4'd3;
      2'd2:    w_psc_last = 4'd7;
      default: w_psc_last = 4'd15;
    endcase
  end

  assign w_run     = r_en & ~r_load;
  assign w_tick    = w_run & (r_psc == w_psc_last);
  assign w_ovf_set = w_tick & ~r_down & (r_tcnt == 8'hFF);
  assign w_udf_set = w_tick & r_down & (r_tcnt == 8'h00);

  // Load-value and control registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tdr  <= 8'h00;
      r_load <= 1'b0;
      r_down <= 1'b0;
      r_en   <= 1'b0;
      r_cks  <= 2'd0;
    end else begin
      if (w_tdr_wr) begin
        r_tdr <= pwdata[7:0];
      end
      if (w_tcr_wr) begin
        r_load <= pwdata[7];
        r_down <= pwdata[5];
        r_en   <= pwdata[4];
        r_cks  <= pwdata[1:0];
      end
    end
  end

  // Prescaler: free-runs while counting is enabled; a CKS change mid-count
  // takes effect once the 4-bit counter naturally reaches the new terminal value
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_psc <= 4'd0;
    end else if (!w_run || w_tick) begin
      r_psc <= 4'd0;
    end else begin
      r_psc <= r_psc + 4'd1;
    end
  end

  // Counter: load has priority over counting
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tcnt <= 8'h00;
    end else if (r_load) begin
      r_tcnt <= r_tdr;
    end else if (w_tick) begin
      r_tcnt <= r_down ? r_tcnt - 8'd1 : r_tcnt + 8'd1;
    end
  end

  // Sticky flags, write-0-to-clear; a hardware set beats a same-cycle clear
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~(w_tsr_wr & ~pwdata[0]));
      r_udf <= w_udf_set | (r_udf & ~(w_tsr_wr & ~pwdata[1]));
    end
  end

  // Read mux; out-of-range addresses return zero
  always_comb begin
    w_rdata = '0;
    if (w_addr_ok) begin
      case (paddr[1:0])
        AddrTdr:  w_rdata[7:0] = r_tdr;
        AddrTcr:  w_rdata[7:0] = {r_load, 1'b0, r_down, r_en, 2'b00, r_cks};
        AddrTsr:  w_rdata[7:0] = {6'd0, r_udf, r_ovf};
        AddrTcnt: w_rdata[7:0] = r_tcnt;
        default:  w_rdata[7:0] = 8'h00;
      endcase
    end
  end

  // Read data is captured in the setup phase and held through the access phase
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_prdata <= '0;
    end else if (w_setup_rd) begin
      r_prdata <= w_rdata;
    end
  end

endmodule

// File: tb/tb_timer_8bit.sv
// Directed self-checking bench for timer_8bit.
// Expected timer values are hand-derived from the transaction timeline: each
// APB transfer spans three negedges (setup, access, idle) and a read returns
// the value held just before its setup-phase posedge.
`timescale 1ns/1ps

module tb_timer_8bit;

  logic       pclk;
  logic       presetn;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int unsigned errors;
  int unsigned checks;

  logic [7:0] rd_data;
  logic       rd_err;
  logic       rd_rdy;

  timer_8bit #(
    .ADDR_W(8),
    .DATA_W(8)
  ) u_dut (
    .pclk   (pclk),
    .presetn(presetn),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic err,
                          output logic rdy);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    d   = prdata;
    err = pslverr;
    rdy = pready;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       e;
    logic       r;
    apb_read(a, d, e, r);
    check(tag, d, exp);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    presetn = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    repeat (3) @(negedge pclk);
    check("reset_prdata", prdata, 8'h00);
    check("reset_pslverr", {7'd0, pslverr}, 8'h00);
    presetn = 1'b1;

    // Reset values and error handling
    rd_chk("reset_tdr", 8'h00, 8'h00);
    rd_chk("reset_tcr", 8'h01, 8'h00);
    rd_chk("reset_tsr", 8'h02, 8'h00);
    apb_read(8'h03, rd_data, rd_err, rd_rdy);
    check("reset_tcnt", rd_data, 8'h00);
    check("ok_pslverr", {7'd0, rd_err}, 8'h00);
    check("pready_access", {7'd0, rd_rdy}, 8'h01);
    apb_read(8'h05, rd_data, rd_err, rd_rdy);
    check("err_rd_data", rd_data, 8'h00);
    check("err_rd_pslverr", {7'd0, rd_err}, 8'h01);
    apb_write(8'h04, 8'hAA);
    apb_write(8'h03, 8'h55);
    apb_write(8'h01, 8'h4C);
    rd_chk("err_wr_no_alias", 8'h00, 8'h00);
    rd_chk("tcnt_read_only", 8'h03, 8'h00);
    rd_chk("tcr_reserved", 8'h01, 8'h00);

    // Up count, CKS 00: tick every 2 pclk
    apb_write(8'h00, 8'h64);
    rd_chk("tdr_rw", 8'h00, 8'h64);
    apb_write(8'h01, 8'h80);
    rd_chk("load_tcnt", 8'h03, 8'h64);
    apb_write(8'h01, 8'h10);
    repeat (271) @(negedge pclk);
    rd_chk("up_136_ticks", 8'h03, 8'hEC);
    rd_chk("up_no_ovf_yet", 8'h02, 8'h00);
    repeat (34) @(negedge pclk);
    rd_chk("up_wrap_tcnt", 8'h03, 8'h00);
    rd_chk("up_ovf_set", 8'h02, 8'h01);
    apb_write(8'h02, 8'h00);
    rd_chk("ovf_w0c", 8'h02, 8'h00);
    rd_chk("runs_after_clr", 8'h03, 8'h06);

    // Down count from 5: six ticks reach 0xFF
    apb_write(8'h00, 8'h05);
    apb_write(8'h01, 8'h80);
    apb_write(8'h01, 8'h30);
    rd_chk("tcr_down_rd", 8'h01, 8'h30);
    repeat (8) @(negedge pclk);
    rd_chk("down_6_ticks", 8'h03, 8'hFF);
    rd_chk("udf_set", 8'h02, 8'h02);
    apb_write(8'h02, 8'hFF);
    rd_chk("udf_w1_keeps", 8'h02, 8'h02);
    apb_write(8'h02, 8'h00);
    rd_chk("udf_w0c", 8'h02, 8'h00);

    // CKS 11: tick every 16 pclk, overflow after 256 pclk
    apb_write(8'h00, 8'hF0);
    apb_write(8'h01, 8'h80);
    apb_write(8'h01, 8'h13);
    rd_chk("cks3_before_tick", 8'h03, 8'hF0);
    repeat (12) @(negedge pclk);
    rd_chk("cks3_first_tick", 8'h03, 8'hF1);
    repeat (200) @(negedge pclk);
    rd_chk("cks3_no_ovf_yet", 8'h02, 8'h00);
    repeat (32) @(negedge pclk);
    // This clear lands on the very edge where the counter wraps
    apb_write(8'h02, 8'h00);
    rd_chk("hw_set_wins", 8'h02, 8'h01);
    rd_chk("cks3_wrap", 8'h03, 8'h00);
    apb_write(8'h02, 8'hFF);
    rd_chk("ovf_w1_keeps", 8'h02, 8'h01);
    apb_write(8'h02, 8'h00);
    rd_chk("ovf_clear2", 8'h02, 8'h00);

    // LOAD held with EN: counter pinned to TDR, no flags
    apb_write(8'h01, 8'h90);
    repeat (50) @(negedge pclk);
    rd_chk("load_hold_tcnt", 8'h03, 8'hF0);
    rd_chk("load_hold_tsr", 8'h02, 8'h00);
    apb_write(8'h01, 8'hFF);
    rd_chk("tcr_mask", 8'h01, 8'hB3);
    rd_chk("load_hold_tcnt2", 8'h03, 8'hF0);

    // Asynchronous reset mid-count
    apb_write(8'h01, 8'h10);
    repeat (20) @(negedge pclk);
    #2;
    presetn = 1'b0;
    #1;
    check("async_rst_prdata", prdata, 8'h00);
    @(negedge pclk);
    presetn = 1'b1;
    rd_chk("post_rst_tdr", 8'h00, 8'h00);
    rd_chk("post_rst_tcr", 8'h01, 8'h00);
    rd_chk("post_rst_tsr", 8'h02, 8'h00);
    repeat (40) @(negedge pclk);
    rd_chk("post_rst_tcnt", 8'h03, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
